// File: rtl/maze_state_pkg.sv
// Shared maze types, geometry and the built-in maze image.
// Imported by the tile store and its ROM.
package maze_state_pkg;

    typedef enum logic [3:0] {
        TILE_EMPTY    = 4'd0,
        TILE_PELLET   = 4'd1,
        TILE_POWER    = 4'd2,
        TILE_WALL_MIN = 4'd3
    } tile_t;

    localparam int MAP_W   = 32;
    localparam int MAP_H   = 36;
    localparam int TILE_PX = 8;
    localparam int TILE_SH = $clog2(TILE_PX);
    localparam int MAP_N   = MAP_W * MAP_H;

    function automatic logic is_wall(tile_t t);
        return t >= TILE_WALL_MIN;
    endfunction

    // Level image: walled border, three pellets and one power pellet.
    function automatic logic [3:0] rom_image(logic [10:0] idx);
        logic [5:0] row;
        logic [4:0] col;
        logic [3:0] t;
        row = idx[10:5];
        col = idx[4:0];
        t   = 4'd0;
        if (idx >= 11'(MAP_N)) begin
            t = 4'd0;
        end else if (row == 6'd0 || row == 6'(MAP_H - 1)) begin
            t = 4'h5;
        end else if (col == 5'd0 || col == 5'(MAP_W - 1)) begin
            t = 4'h9;
        end else if (idx == 11'd129 || idx == 11'd130 || idx == 11'd200) begin
            t = 4'd1;
        end else if (idx == 11'd300) begin
            t = 4'd2;
        end
        return t;
    endfunction

endpackage

// File: rtl/maze_state_rom.sv
// Synchronous 1152x4 maze ROM: address in, tile code out one cycle later.
// Contents come from the package level image.
module maze_rom
    import maze_state_pkg::*;
(
    input  logic        vga_pix_clk,
    input  logic [10:0] addr,
    output logic [3:0]  data
);

    logic [3:0] data_d;
    logic [3:0] data_q;

    // Look up the tile code for the requested address.
    always_comb begin
        data_d = rom_image(addr);
    end

    // Register the ROM output.
    always_ff @(posedge vga_pix_clk) begin
        data_q <= data_d;
    end

    assign data = data_q;

endmodule

// File: rtl/maze_state.sv
// Live maze tile store: copies the ROM at start, eats pellets under pacman,
// keeps score / pellet count and drives the wall view for movement.
module maze_state
    import maze_state_pkg::*;
#(
    parameter int PELLET_PTS = 10,
    parameter int POWER_PTS  = 50
) (
    input  logic               vga_pix_clk,
    input  logic               rst,
    input  logic               frame_stb,
    input  logic [8:0]         x_pac,
    input  logic [8:0]         y_pac,
    input  logic [10:0]        rd_idx,
    output logic [3:0]         rd_tile,
    output logic [4*MAP_N-1:0] MAP,
    output logic               init_done,
    output logic [15:0]        score,
    output logic [10:0]        pellets_left,
    output logic               power_stb,
    output logic               level_clear
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t      state_q, state_d;
    logic [10:0] init_cnt_q, init_cnt_d;
    logic        fill_vld_q, fill_vld_d;
    logic [10:0] fill_idx_q, fill_idx_d;
    logic        init_done_q, init_done_d;
    logic        eat_vld_q, eat_vld_d;
    logic [10:0] eat_idx_q, eat_idx_d;
    logic [15:0] score_q, score_d;
    logic [10:0] pellets_q, pellets_d;
    logic        power_q, power_d;
    logic        clear_q, clear_d;
    logic [3:0]  rd_tile_q, rd_tile_d;
    logic [3:0]  store_q [MAP_N];
    logic [3:0]  store_d [MAP_N];

    logic        issue;
    logic [10:0] rom_addr;
    logic [3:0]  rom_data;
    logic        aligned;
    logic [10:0] pac_idx;
    logic [3:0]  eat_code;
    logic        eat_hit;
    logic [16:0] score_sum;
    logic [4*MAP_N-1:0] map_view;

    maze_rom u_rom (
        .vga_pix_clk (vga_pix_clk),
        .addr        (rom_addr),
        .data        (rom_data)
    );

    // State register.
    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave INIT once the last tile has landed in the store.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_INIT: begin
                if (fill_vld_q && fill_idx_q == 11'(MAP_N - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // Copy pipeline, eat pipeline, scoring and read port.
    always_comb begin
        issue      = (state_q == S_INIT) && (init_cnt_q < 11'(MAP_N));
        init_cnt_d = issue ? init_cnt_q + 11'd1 : init_cnt_q;
        rom_addr   = init_cnt_q;
        fill_vld_d = issue;
        fill_idx_d = init_cnt_q;
        init_done_d = (state_q == S_RUN);

        aligned = ((x_pac & 9'(TILE_PX - 1)) == 9'd0)
               && ((y_pac & 9'(TILE_PX - 1)) == 9'd0);
        pac_idx = 11'(x_pac >> TILE_SH)
                + 11'(y_pac >> TILE_SH) * 11'(MAP_W);
        eat_vld_d = frame_stb && init_done_q && (state_q == S_RUN)
                 && aligned && (pac_idx < 11'(MAP_N));
        eat_idx_d = pac_idx;

        store_d   = store_q;
        score_d   = score_q;
        pellets_d = pellets_q;
        power_d   = 1'b0;
        clear_d   = clear_q;
        score_sum = 17'd0;

        if (fill_vld_q) begin
            store_d[fill_idx_q] = rom_data;
            if (rom_data == TILE_PELLET || rom_data == TILE_POWER) begin
                pellets_d = pellets_q + 11'd1;
            end
        end

        eat_code = store_q[eat_idx_q];
        eat_hit  = eat_vld_q && (pellets_q != 11'd0)
                && (eat_code == TILE_PELLET || eat_code == TILE_POWER);
        if (eat_hit) begin
            store_d[eat_idx_q] = TILE_EMPTY;
            if (eat_code == TILE_POWER) begin
                score_sum = {1'b0, score_q} + 17'(POWER_PTS);
            end else begin
                score_sum = {1'b0, score_q} + 17'(PELLET_PTS);
            end
            score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            pellets_d = pellets_q - 11'd1;
            power_d   = (eat_code == TILE_POWER);
            if (pellets_q == 11'd1) begin
                clear_d = 1'b1;
            end
        end

        rd_tile_d = (rd_idx < 11'(MAP_N)) ? store_q[rd_idx] : 4'd0;
    end

    // Wall view: walls only, everything reads as wall until the copy is done.
    always_comb begin
        for (int i = 0; i < MAP_N; i++) begin
            if (!init_done_q) begin
                map_view[4*i +: 4] = 4'hF;
            end else if (is_wall(tile_t'(store_q[i]))) begin
                map_view[4*i +: 4] = store_q[i];
            end else begin
                map_view[4*i +: 4] = 4'h0;
            end
        end
    end

    // Control and counter flops with synchronous reset.
    always_ff @(posedge vga_pix_clk) begin
        if (rst) begin
            init_cnt_q  <= 11'd0;
            fill_vld_q  <= 1'b0;
            init_done_q <= 1'b0;
            eat_vld_q   <= 1'b0;
            score_q     <= 16'd0;
            pellets_q   <= 11'd0;
            power_q     <= 1'b0;
            clear_q     <= 1'b0;
            rd_tile_q   <= 4'd0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            fill_vld_q  <= fill_vld_d;
            init_done_q <= init_done_d;
            eat_vld_q   <= eat_vld_d;
            score_q     <= score_d;
            pellets_q   <= pellets_d;
            power_q     <= power_d;
            clear_q     <= clear_d;
            rd_tile_q   <= rd_tile_d;
        end
    end

    // Tile store and pipeline indices; qualified by their valid flops.
    always_ff @(posedge vga_pix_clk) begin
        fill_idx_q <= fill_idx_d;
        eat_idx_q  <= eat_idx_d;
        store_q    <= store_d;
    end

    assign rd_tile      = rd_tile_q;
    assign MAP          = map_view;
    assign init_done    = init_done_q;
    assign score        = score_q;
    assign pellets_left = pellets_q;
    assign power_stb    = power_q;
    assign level_clear  = clear_q;

endmodule

// File: tb/tb_maze_state.sv
// Self-checking bench for maze_state: copy timing, eating, scoring,
// saturation, level clear and read port behaviour.
module tb_maze_state;

    logic               vga_pix_clk = 1'b0;
    logic               rst;
    logic               frame_stb;
    logic [8:0]         x_pac;
    logic [8:0]         y_pac;
    logic [10:0]        rd_idx;
    logic [3:0]         rd_tile;
    logic [4*1152-1:0]  MAP;
    logic               init_done;
    logic [15:0]        score;
    logic [10:0]        pellets_left;
    logic               power_stb;
    logic               level_clear;

    maze_state dut (
        .vga_pix_clk  (vga_pix_clk),
        .rst          (rst),
        .frame_stb    (frame_stb),
        .x_pac        (x_pac),
        .y_pac        (y_pac),
        .rd_idx       (rd_idx),
        .rd_tile      (rd_tile),
        .MAP          (MAP),
        .init_done    (init_done),
        .score        (score),
        .pellets_left (pellets_left),
        .power_stb    (power_stb),
        .level_clear  (level_clear)
    );

    initial forever #5 vga_pix_clk = ~vga_pix_clk;

    typedef struct {
        int          due;
        logic [15:0] score;
        logic [10:0] pel;
        logic        pwr;
        logic        lvl;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] rd_q[$];
    exp_t       e_mon;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    logic mon_en = 1'b0;

    logic [3:0] m_tile [1152];
    int m_score;
    int m_pel;
    logic m_lvl;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(posedge vga_pix_clk) cyc <= cyc + 1;

    always @(negedge vga_pix_clk) begin
        if (mon_en) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e_mon = sb_q.pop_front();
                chk("score", 32'(score), 32'(e_mon.score));
                chk("pellets", 32'(pellets_left), 32'(e_mon.pel));
                chk("power_stb", 32'(power_stb), 32'(e_mon.pwr));
                chk("level_clear", 32'(level_clear), 32'(e_mon.lvl));
            end else begin
                chk("power_idle", 32'(power_stb), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge vga_pix_clk);
        @(negedge vga_pix_clk);
    endtask

    task automatic idle(input int k);
        repeat (k) step();
    endtask

    task automatic rd(input int idx, input int exp_v, input string tag);
        logic [3:0] e;
        rd_idx = 11'(idx);
        rd_q.push_back(4'(exp_v));
        step();
        e = rd_q.pop_front();
        chk(tag, 32'(rd_tile), 32'(e));
    endtask

    task automatic strobe(input int x, input int y);
        exp_t e;
        int idx;
        int pts;
        x_pac = 9'(x);
        y_pac = 9'(y);
        frame_stb = 1'b1;
        idx = ((x / 8) + (y / 8) * 32) % 2048;
        e.pwr = 1'b0;
        if (x % 8 == 0 && y % 8 == 0 && idx < 1152 && m_pel > 0
            && (m_tile[idx] == 4'd1 || m_tile[idx] == 4'd2)) begin
            pts = (m_tile[idx] == 4'd2) ? 50 : 10;
            e.pwr = (m_tile[idx] == 4'd2);
            m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
            m_tile[idx] = 4'd0;
            m_pel--;
            if (m_pel == 0) m_lvl = 1'b1;
        end
        e.due   = cyc + 2;
        e.score = 16'(m_score);
        e.pel   = 11'(m_pel);
        e.lvl   = m_lvl;
        sb_q.push_back(e);
        step();
        frame_stb = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 1152; i++) m_tile[i] = 4'd0;
        m_tile[129] = 4'd1;
        m_tile[130] = 4'd1;
        m_tile[200] = 4'd1;
        m_tile[300] = 4'd2;
        m_score = 0;
        m_pel = 4;
        m_lvl = 1'b0;

        rst = 1'b1;
        frame_stb = 1'b0;
        x_pac = '0;
        y_pac = '0;
        rd_idx = '0;
        idle(3);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_pellets", 32'(pellets_left), 32'd0);
        chk("rst_power", 32'(power_stb), 32'd0);
        chk("rst_level", 32'(level_clear), 32'd0);
        chk("rst_rd_tile", 32'(rd_tile), 32'd0);
        chk("rst_map_all_f", 32'(MAP == '1), 32'd1);

        rst = 1'b0;
        idle(500);
        chk("mid_init_count", 32'(pellets_left), 32'd4);
        chk("mid_init_done", 32'(init_done), 32'd0);
        rst = 1'b1;
        step();
        chk("rerst_count", 32'(pellets_left), 32'd0);
        chk("rerst_done", 32'(init_done), 32'd0);
        rst = 1'b0;

        n = 0;
        while (!init_done && n < 2000) begin
            if (n == 600) chk("init_map_all_f", 32'(MAP == '1), 32'd1);
            if (n == 700) begin
                x_pac = 9'd8;
                y_pac = 9'd32;
                frame_stb = 1'b1;
            end else begin
                frame_stb = 1'b0;
            end
            step();
            n++;
        end
        frame_stb = 1'b0;
        chk("init_latency_ok", 32'(n >= 1153 && n <= 1155), 32'd1);
        chk("init_pellets", 32'(pellets_left), 32'd4);
        chk("init_score", 32'(score), 32'd0);
        chk("map_top_wall", 32'(MAP[0 +: 4]), 32'h5);
        chk("map_side_wall", 32'(MAP[4*32 +: 4]), 32'h9);
        chk("map_pellet", 32'(MAP[4*129 +: 4]), 32'h0);
        chk("map_power", 32'(MAP[4*300 +: 4]), 32'h0);

        rd(129, 1, "rd_pellet");
        rd(300, 2, "rd_power");
        rd(1200, 0, "rd_oob");
        rd(31, 5, "rd_wall_top");
        rd(1151, 5, "rd_wall_bot");

        mon_en = 1'b1;
        strobe(8, 32);
        idle(3);
        rd(129, 0, "rd_eaten_129");
        chk("map_eaten_129", 32'(MAP[4*129 +: 4]), 32'h0);

        strobe(17, 32);
        strobe(16, 33);
        idle(3);
        rd(130, 1, "rd_unaligned_kept");

        strobe(96, 72);
        idle(3);

        strobe(64, 48);
        rd(200, 1, "rd_before_write");
        rd(200, 0, "rd_after_write");
        idle(3);

        force dut.score_q = 16'hFFF8;
        step();
        release dut.score_q;
        step();
        chk("preload_score", 32'(score), 32'hFFF8);
        m_score = 16'hFFF8;

        strobe(16, 32);
        strobe(16, 32);
        idle(3);
        chk("level_set", 32'(level_clear), 32'd1);

        strobe(8, 32);
        strobe(0, 288);
        idle(4);
        chk("level_sticky", 32'(level_clear), 32'd1);
        chk("score_held", 32'(score), 32'hFFFF);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
